// File: rtl/sorted_stream_pkg.sv
// Shared types and defaults for the sorted-stream transmit path.
package sorted_stream_pkg;

    localparam int N_ELEM_DEFAULT = 8;
    localparam int WIDTH_DEFAULT  = 8;
    localparam int CNT_W          = $clog2(N_ELEM_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        WAIT_LOW,
        DONE
    } state_t;

endpackage

// File: rtl/sorted_stream_tx_sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops so q is safe to use in clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sorted_stream_tx.sv
// Captures one frame of sorted elements and sends them to the host with a
// four-phase valid/ack handshake. The host ack is synchronised before use.
// Optional checksum beat: define SORTED_STREAM_TX_CHECKSUM_EN to append the
// XOR of all captured elements as one extra beat after the data.
module sorted_stream_tx
    import sorted_stream_pkg::*;
#(
    parameter int N_ELEM = N_ELEM_DEFAULT,
    parameter int WIDTH  = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             tx_ack_async,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW       = $clog2(N_ELEM);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);

    state_t           state;
    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;
    logic [CW:0]      len;
    logic [WIDTH-1:0] buffer [N_ELEM];
    logic             ack_s;
    logic             accept;
    logic             end_frame;
    logic             last_beat;
    logic [CW-1:0]    next_rd;

`ifdef SORTED_STREAM_TX_CHECKSUM_EN
    logic [WIDTH-1:0] csum;
    logic             csum_beat;
`endif

    sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_ack_async),
        .q     (ack_s)
    );

    // in_ready is high exactly while capturing, so accept is the capture handshake.
    // The final slot closes the frame even without in_last, so counters never wrap.
    assign accept    = in_valid && in_ready;
    assign end_frame = accept && (in_last || (wr_cnt == LAST_IDX));
    assign last_beat = ({1'b0, rd_cnt} == (len - (CW+1)'(1)));
    assign next_rd   = rd_cnt + CW'(1);
    assign busy      = (state != IDLE);

    // Buffer write port; contents are deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            buffer[wr_cnt] <= in_data;
        end
    end

`ifdef SORTED_STREAM_TX_CHECKSUM_EN
    // Running XOR of everything captured in the current frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == DONE) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    // Main frame FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            len        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
`ifdef SORTED_STREAM_TX_CHECKSUM_EN
            csum_beat  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A stuck-high ack keeps us here so no frame starts mid-handshake
                    if (!ack_s) begin
                        state    <= CAPTURE;
                        in_ready <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (end_frame) begin
                        len      <= {1'b0, wr_cnt} + (CW+1)'(1);
                        state    <= SEND;
                        in_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        // A one-element frame is still being written, so bypass the buffer
                        tx_data  <= (wr_cnt == '0) ? in_data : buffer[0];
                    end else if (accept) begin
                        wr_cnt <= wr_cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (ack_s) begin
                        tx_valid <= 1'b0;
                        state    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!ack_s) begin
`ifdef SORTED_STREAM_TX_CHECKSUM_EN
                        if (csum_beat) begin
                            csum_beat  <= 1'b0;
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else if (last_beat) begin
                            csum_beat <= 1'b1;
                            state     <= SEND;
                            tx_valid  <= 1'b1;
                            tx_data   <= csum;
                        end else begin
                            rd_cnt   <= next_rd;
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= buffer[next_rd];
                        end
`else
                        if (last_beat) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            rd_cnt   <= next_rd;
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= buffer[next_rd];
                        end
`endif
                    end
                end
                DONE: begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    len    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_stream_tx.sv
// Self-checking bench for sorted_stream_tx: random-timed feeder and host
// against a queue-based model of the beats the host should observe.
module tb_sorted_stream_tx;

    typedef logic [7:0] byteq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       tx_ack_async = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_fails = 0;
    int done_count = 0;
    int frames_expected = 0;

    sorted_stream_tx #(.N_ELEM(8), .WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .tx_ack_async (tx_ack_async),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_count++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beats the host must see: frame closes at in_last or after 8 elements,
    // optionally followed by the XOR of the captured elements
    function automatic byteq_t model_frame(input byteq_t vals);
        byteq_t     beats;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < vals.size() && i < 8; i++) begin
            beats.push_back(vals[i]);
            x = x ^ vals[i];
        end
`ifdef SORTED_STREAM_TX_CHECKSUM_EN
        beats.push_back(x);
`endif
        return beats;
    endfunction

    task automatic wait_capture();
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL capture_entry: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic feed(input byteq_t vals, input bit mark_last, input bit hold_aa);
        int w;
        int gaps;
        for (int i = 0; i < vals.size(); i++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            in_last  = mark_last && (i == vals.size() - 1);
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL feed_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            tick();
        end
        in_last = 1'b0;
        if (hold_aa) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Four-phase host; ack_delay < 0 picks a random response time.
    // Returns early once beat abort_at is presented.
    task automatic run_host(input byteq_t exp, input int ack_delay, input int abort_at);
        int w;
        int lat;
        int d;
        for (int i = 0; i < exp.size(); i++) begin
            w = 0;
            while (tx_valid !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            n_checks++;
            if (tx_valid !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL beat_timeout[%0d]: tx_valid=%b expected 1", i, tx_valid);
                return;
            end
            if (i == abort_at) return;
            n_checks++;
            if (tx_data !== exp[i]) begin
                n_fails++;
                $display("[TB] FAIL beat_data[%0d]: tx_data=%h expected %h", i, tx_data, exp[i]);
            end
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL send_flags[%0d]: in_ready=%b busy=%b expected 0 1", i, in_ready, busy);
            end
            d = (ack_delay < 0) ? $urandom_range(0, 4) : ack_delay;
            repeat (d) tick();
            tx_ack_async = 1'b1;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (tx_valid === 1'b1 && lat < 10);
            n_checks++;
            if (lat != 3) begin
                n_fails++;
                $display("[TB] FAIL ack_latency[%0d]: edges=%0d expected 3", i, lat);
            end
            n_checks++;
            if (tx_data !== exp[i]) begin
                n_fails++;
                $display("[TB] FAIL data_hold[%0d]: tx_data=%h expected %h", i, tx_data, exp[i]);
            end
            repeat ($urandom_range(0, 3)) tick();
            tx_ack_async = 1'b0;
        end
        w = 0;
        while (frame_done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL frame_done: got %b expected 1", frame_done);
        end else begin
            frames_expected++;
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL post_done: frame_done=%b busy=%b expected 0 0", frame_done, busy);
        end
    endtask

    // Host that keeps ack high and only drops it for one cycle between beats
    task automatic run_host_immediate(input byteq_t exp);
        int w;
        for (int i = 0; i < exp.size(); i++) begin
            w = 0;
            while (tx_valid !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            n_checks++;
            if (tx_valid !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL imm_timeout[%0d]: tx_valid=%b expected 1", i, tx_valid);
                return;
            end
            n_checks++;
            if (tx_data !== exp[i]) begin
                n_fails++;
                $display("[TB] FAIL imm_data[%0d]: tx_data=%h expected %h", i, tx_data, exp[i]);
            end
            tick();
            n_checks++;
            if (tx_valid !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL imm_pulse[%0d]: tx_valid=%b expected 0", i, tx_valid);
            end
            tx_ack_async = 1'b0;
            tick();
            tx_ack_async = 1'b1;
        end
        w = 0;
        while (frame_done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL imm_frame_done: got %b expected 1", frame_done);
        end else begin
            frames_expected++;
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL imm_busy: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({tx_valid, tx_data, busy, in_ready, frame_done} !== 12'h000) begin
            n_fails++;
            $display("[TB] FAIL reset_state: valid=%b data=%h busy=%b ready=%b done=%b expected all 0",
                     tx_valid, tx_data, busy, in_ready, frame_done);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL reset_release: in_ready=%b busy=%b expected 1 1", in_ready, busy);
        end
    endtask

    task automatic test_full_frame();
        byteq_t v;
        v = '{8'h01, 8'h03, 8'h07, 8'h10, 8'h22, 8'h40, 8'h80, 8'hFF};
        feed(v, 1'b0, 1'b0);
        run_host(model_frame(v), 3, -1);
    endtask

    task automatic test_short_frame();
        byteq_t v;
        v = '{8'h05, 8'h06, 8'h09};
        feed(v, 1'b1, 1'b0);
        run_host(model_frame(v), -1, -1);
    endtask

    task automatic test_single_element();
        byteq_t v;
        v = '{8'h5C};
        feed(v, 1'b1, 1'b0);
        run_host(model_frame(v), -1, -1);
    endtask

    task automatic test_backpressure();
        byteq_t v;
        for (int i = 0; i < 8; i++) v.push_back(8'($urandom_range(0, 255)));
        feed(v, 1'b0, 1'b1);
        run_host(model_frame(v), -1, -1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        byteq_t v;
        byteq_t v2;
        int     dc;
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        feed(v, 1'b0, 1'b0);
        run_host(model_frame(v), -1, 3);
        dc = done_count;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL mid_reset: valid=%b data=%h busy=%b ready=%b expected 0 00 0 0",
                     tx_valid, tx_data, busy, in_ready);
        end
        tx_ack_async = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (done_count != dc) begin
            n_fails++;
            $display("[TB] FAIL abort_no_done: pulses=%0d expected %0d", done_count, dc);
        end
        for (int i = 0; i < 8; i++) v2.push_back(8'(8'h11 + i));
        feed(v2, 1'b0, 1'b0);
        run_host(model_frame(v2), -1, -1);
    endtask

    task automatic test_random_frames();
        byteq_t v;
        int     n;
        bit     ml;
        for (int f = 0; f < 4; f++) begin
            v = {};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) v.push_back(8'($urandom_range(0, 255)));
            ml = (n < 8) ? 1'b1 : 1'($urandom);
            feed(v, ml, 1'b0);
            run_host(model_frame(v), -1, -1);
        end
    endtask

    task automatic test_immediate_ack();
        byteq_t v;
        for (int i = 0; i < 8; i++) v.push_back(8'($urandom_range(0, 255)));
        wait_capture();
        tx_ack_async = 1'b1;
        feed(v, 1'b0, 1'b0);
        run_host_immediate(model_frame(v));
    endtask

    // Entered with ack still high from the immediate-ack host
    task automatic test_stuck_ack();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL stuck_idle[%0d]: in_ready=%b busy=%b expected 0 0", i, in_ready, busy);
            end
        end
        tx_ack_async = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL stuck_release_early: in_ready=%b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL stuck_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_single_element();
        test_backpressure();
        test_reset_mid_send();
        test_random_frames();
        test_immediate_ack();
        test_stuck_ack();
        repeat (3) tick();
        n_checks++;
        if (done_count != frames_expected) begin
            n_fails++;
            $display("[TB] FAIL done_pulses: got %0d expected %0d", done_count, frames_expected);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
